// File: rtl/mem_access_stage.sv
// MIPS MEM stage: executes lw/sw against a word-addressed data RAM through a
// req/ack handshake and stalls upstream while an access is outstanding.
// Non-memory instructions pass through to write-back with one-cycle latency.
// Optional build macro MEM_ALIGN_CHECK_EN: adds the misaligned output and
// turns word-misaligned lw/sw into non-RAM write-back bubbles.
//
// state | meaning
// IDLE  | accepting a new instruction from EX/MEM
// WAIT  | RAM request outstanding, upstream stalled
module mem_access_stage #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [31:0]           ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_write_data,
  input  logic                  ex_reg_write,
  input  logic [4:0]            ex_write_reg,
  output logic                  stall,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_ack,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_write_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [31:0]           stall_count
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  misaligned
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_we_q, ram_we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  lat_rw_q, lat_rw_d;
  logic [4:0]            lat_rd_q, lat_rd_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [4:0]            wb_write_reg_q, wb_write_reg_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [31:0]           stall_count_q, stall_count_d;
  logic                  is_mem_op;
  logic                  addr_misaligned;
`ifdef MEM_ALIGN_CHECK_EN
  logic                  misaligned_q, misaligned_d;
`endif

  assign stall        = (state_q == S_WAIT);
  assign ram_req      = ram_req_q;
  assign ram_we       = ram_we_q;
  // The word address is always a slice of the latched byte address, so it is
  // stable for the whole WAIT period by construction.
  assign ram_addr     = addr_q[ADDR_WIDTH+1:2];
  assign ram_wdata    = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_write_reg = wb_write_reg_q;
  assign wb_data      = wb_data_q;
  assign stall_count  = stall_count_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned   = misaligned_q;
`endif

  // Classify the incoming instruction
  always_comb begin
    is_mem_op = ex_mem_read | ex_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
    addr_misaligned = (ex_alu_result[1:0] != 2'b00);
`else
    addr_misaligned = 1'b0;
`endif
  end

  // Next-state, RAM request and write-back slot computation
  always_comb begin
    state_d        = state_q;
    ram_req_d      = ram_req_q;
    ram_we_d       = ram_we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    lat_rw_d       = lat_rw_q;
    lat_rd_d       = lat_rd_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_write_reg_d = wb_write_reg_q;
    wb_data_d      = wb_data_q;
    stall_count_d  = stall_count_q;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned_d   = misaligned_q;
`endif

    if ((state_q == S_WAIT) && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
`ifdef MEM_ALIGN_CHECK_EN
          misaligned_d = is_mem_op & addr_misaligned;
`endif
          if (is_mem_op && !addr_misaligned) begin
            state_d   = S_WAIT;
            ram_req_d = 1'b1;
            ram_we_d  = ex_mem_write;  // write wins when both are set
            addr_d    = ex_alu_result;
            wdata_d   = ex_write_data;
            lat_rw_d  = ex_reg_write;
            lat_rd_d  = ex_write_reg;
          end else begin
            // Pass-through, or a rejected misaligned access that must not
            // write the register file.
            wb_valid_d     = 1'b1;
            wb_reg_write_d = is_mem_op ? 1'b0 : ex_reg_write;
            wb_write_reg_d = ex_write_reg;
            wb_data_d      = ex_alu_result;
          end
        end
      end
      S_WAIT: begin
        if (ram_ack) begin
          state_d        = S_IDLE;
          ram_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          wb_write_reg_d = lat_rd_q;
          if (ram_we_q) begin
            wb_data_d      = addr_q;
            wb_reg_write_d = 1'b0;
          end else begin
            wb_data_d      = ram_rdata;
            wb_reg_write_d = lat_rw_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ram_req_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      lat_rw_q       <= 1'b0;
      lat_rd_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_write_reg_q <= '0;
      wb_data_q      <= '0;
      stall_count_q  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ram_req_q      <= ram_req_d;
      ram_we_q       <= ram_we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      lat_rw_q       <= lat_rw_d;
      lat_rd_q       <= lat_rd_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_write_reg_q <= wb_write_reg_d;
      wb_data_q      <= wb_data_d;
      stall_count_q  <= stall_count_d;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned_q   <= misaligned_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a transaction-level reference
// model and a per-cycle compare process. Works with or without
// MEM_ALIGN_CHECK_EN defined.
module tb_mem_access_stage;
  localparam int AW = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [31:0] ex_alu_result = '0, ex_write_data = '0;
  logic        ex_reg_write = 1'b0;
  logic [4:0]  ex_write_reg = '0;
  logic        stall, ram_req, ram_we, ram_ack = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data, stall_count;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  mem_access_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .stall(stall), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .stall_count(stall_count)
`ifdef MEM_ALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM seen by the DUT
  logic [31:0] mem [0:(1<<AW)-1];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clock)
    if (ram_req && ram_we && ram_ack) mem[ram_addr] <= ram_wdata;

  // Reference model: one optional pending access plus the expected WB slot.
  logic [31:0] mmem [0:(1<<AW)-1];
  bit          m_busy, m_write, m_rw, m_wbv, m_wbrw, m_mis;
  logic [31:0] m_addr, m_data, m_wbdata, m_cnt;
  logic [4:0]  m_rd, m_wbrd;

  function automatic logic [31:0] widx(input logic [31:0] a);
    return {22'd0, a[AW+1:2]};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 0; m_write = 0; m_rw = 0; m_wbv = 0; m_wbrw = 0; m_mis = 0;
      m_addr = 0; m_data = 0; m_wbdata = 0; m_cnt = 0; m_rd = 0; m_wbrd = 0;
    end else begin
      if (m_busy && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_wbv = 0; m_wbrw = 0;
      if (m_busy) begin
        if (ram_ack) begin
          m_busy = 0; m_wbv = 1; m_wbrd = m_rd;
          if (m_write) begin
            mmem[widx(m_addr)] = m_data;
            m_wbdata = m_addr;
          end else begin
            m_wbdata = mmem[widx(m_addr)];
            m_wbrw = m_rw;
          end
        end
      end else if (ex_valid) begin
        bit memop, bad;
        memop = ex_mem_read || ex_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
        bad = memop && (ex_alu_result[1:0] != 0);
`else
        bad = 0;
`endif
        m_mis = bad;
        if (memop && !bad) begin
          m_busy = 1; m_write = ex_mem_write; m_addr = ex_alu_result;
          m_data = ex_write_data; m_rw = ex_reg_write; m_rd = ex_write_reg;
        end else begin
          m_wbv = 1; m_wbrw = memop ? 0 : ex_reg_write;
          m_wbrd = ex_write_reg; m_wbdata = ex_alu_result;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, m_busy});
      chk("ram_req", {31'd0, ram_req}, {31'd0, m_busy});
      if (m_busy) begin
        chk("ram_we", {31'd0, ram_we}, {31'd0, m_write});
        chk("ram_addr", {22'd0, ram_addr}, widx(m_addr));
        if (m_write) chk("ram_wdata", ram_wdata, m_data);
      end
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_wbv});
      if (m_wbv) begin
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, m_wbrw});
        chk("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, m_wbrd});
        chk("wb_data", wb_data, m_wbdata);
      end
      chk("stall_count", stall_count, m_cnt);
`ifdef MEM_ALIGN_CHECK_EN
      chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ex_valid = 1'b0; ram_ack = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Issue one memory op, acking after nwait non-ack WAIT cycles.
  task automatic mem_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit rw, input logic [4:0] rdreg,
                        input int nwait, output int req_cycles);
    ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_alu_result = addr;
    ex_write_data = wd; ex_reg_write = rw; ex_write_reg = rdreg;
    req_cycles = 0;
    step();
    for (int i = 0; i <= nwait; i++) begin
      if (ram_req) req_cycles++;
      if (i == nwait) ram_ack = 1'b1;
      step();
    end
    ram_ack = 1'b0; ex_valid = 1'b0; ex_mem_read = 0; ex_mem_write = 0;
  endtask

  int rq;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'h0; mmem[i] = 32'h0;
    end
    mem[2] = 32'h1234_5678; mmem[2] = 32'h1234_5678;

    do_reset();
    chk_en = 1'b1;
    chk("rst_stall_count", stall_count, 32'd0);
    chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);

    // Pass-through
    ex_valid = 1; ex_alu_result = 32'h2A; ex_reg_write = 1; ex_write_reg = 5'd9;
    step();
    ex_valid = 0;
    chk("pt_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("pt_wb_data", wb_data, 32'h2A);
    chk("pt_wb_write_reg", {27'd0, wb_write_reg}, 32'd9);
    chk("pt_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("pt_stall", {31'd0, stall}, 32'd0);
    step();

    // lw, zero wait
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_alu_result = 32'h8; ex_reg_write = 1; ex_write_reg = 5'd4;
    step();
    chk("lw_ram_req", {31'd0, ram_req}, 32'd1);
    chk("lw_ram_addr", {22'd0, ram_addr}, 32'd2);
    chk("lw_ram_we", {31'd0, ram_we}, 32'd0);
    ram_ack = 1;
    step();
    ram_ack = 0; ex_valid = 0; ex_mem_read = 0;
    chk("lw_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lw_wb_data", wb_data, 32'h1234_5678);
    chk("lw_stall_after", {31'd0, stall}, 32'd0);
    chk("lw_stall_count", stall_count, 32'd1);
    step();

    // sw, 3 wait cycles
    do_reset();
    mem_op(0, 1, 32'hC, 32'hDEAD_BEEF, 1, 5'd7, 3, rq);
    chk("sw_req_cycles", rq, 32'd4);
    chk("sw_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sw_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("sw_wb_data", wb_data, 32'hC);
    chk("sw_stall_count", stall_count, 32'd4);
    chk("sw_mem", mem[3], 32'hDEAD_BEEF);
    step();

    // Back-to-back sw then lw to the same word
    do_reset();
    mem_op(0, 1, 32'h8, 32'hCAFE_F00D, 0, 5'd0, 1, rq);
    mem_op(1, 0, 32'h8, 32'h0, 1, 5'd12, 1, rq);
    chk("b2b_lw_data", wb_data, 32'hCAFE_F00D);
    chk("b2b_lw_reg", {27'd0, wb_write_reg}, 32'd12);
    chk("b2b_stall_count", stall_count, 32'd4);
    step();

    // Reset in the 2nd WAIT cycle, then a late ack
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_alu_result = 32'h10; ex_reg_write = 1; ex_write_reg = 5'd3;
    step();
    ex_valid = 0; ex_mem_read = 0;
    step();
    reset = 1;
    step();
    reset = 0; ram_ack = 1;
    chk("rw_ram_req", {31'd0, ram_req}, 32'd0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    step();
    ram_ack = 0;
    chk("rw_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rw_stall_count", stall_count, 32'd0);
    chk("rw_ram_req2", {31'd0, ram_req}, 32'd0);
    step();

    // Misaligned lw address 0x6
    do_reset();
    ex_valid = 1; ex_mem_read = 1; ex_alu_result = 32'h6; ex_reg_write = 1; ex_write_reg = 5'd2;
    step();
`ifdef MEM_ALIGN_CHECK_EN
    ex_valid = 0; ex_mem_read = 0;
    chk("mis_ram_req", {31'd0, ram_req}, 32'd0);
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("mis_wb_data", wb_data, 32'h6);
    ex_valid = 1; ex_alu_result = 32'h1; ex_reg_write = 1; ex_write_reg = 5'd1;
    step();
    ex_valid = 0;
    chk("mis_clear", {31'd0, misaligned}, 32'd0);
`else
    chk("unal_ram_req", {31'd0, ram_req}, 32'd1);
    chk("unal_ram_addr", {22'd0, ram_addr}, 32'd1);
    ram_ack = 1;
    step();
    ram_ack = 0; ex_valid = 0; ex_mem_read = 0;
    chk("unal_wb_valid", {31'd0, wb_valid}, 32'd1);
`endif
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end
endmodule
